// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DATA_W = 24;

    // Owner of the most recent grant.
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_CORE  = 2'd1,
        OWN_HOST  = 2'd2,
        OWN_HLOCK = 2'd3
    } owner_e;

    // Destination of the read data arriving from the RAM this cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_HOST = 2'd2
    } rtag_e;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of consecutive refused request cycles for one requester;
// sat flags that the requester must win its next contention.
module arb_wait_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic sat
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on grant or dropped request, else saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q != MAX_C) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data RAM with lock bursts and read routing.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise core has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              stall_core,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LOCK_C = LW'(LOCK_MAX);

    owner_e            owner_q, owner_d;
    rtag_e             tag_q, tag_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              core_sat, host_sat;

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_core_wait (
        .clk(clk), .reset(reset), .req(core_req), .gnt(core_gnt), .sat(core_sat)
    );

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_host_wait (
        .clk(clk), .reset(reset), .req(host_req), .gnt(host_gnt), .sat(host_sat)
    );

    // Grant selection: starvation forcing, then lock bursts, then contention policy.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (reset) begin
            core_gnt = 1'b0;
            host_gnt = 1'b0;
        end else if (core_req && host_req) begin
            if (core_sat) begin
                core_gnt = 1'b1;
            end else if (host_sat) begin
                host_gnt = 1'b1;
            end else if (owner_q == OWN_HLOCK) begin
                if (lock_cnt_q < LOCK_C) begin
                    host_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
            end else begin
`ifdef DMEM_ARB_RR_EN
                // IDLE is treated as "host last", so core takes the first contention.
                if (owner_q == OWN_CORE) begin
                    host_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
`else
                core_gnt = 1'b1;
`endif
            end
        end else if (core_req) begin
            core_gnt = 1'b1;
        end else if (host_req) begin
            host_gnt = 1'b1;
        end else begin
            core_gnt = 1'b0;
            host_gnt = 1'b0;
        end
    end

    // RAM command mux, owner/lock/tag next state and read-return routing.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        owner_d     = OWN_IDLE;
        lock_cnt_d  = {LW{1'b0}};
        tag_d       = TAG_NONE;
        if (core_gnt) begin
            mem_addr_d  = core_addr;
            mem_wdata_d = core_wdata;
            mem_we_d    = core_we;
            owner_d     = OWN_CORE;
            tag_d       = core_we ? TAG_NONE : TAG_CORE;
        end else if (host_gnt) begin
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
            mem_we_d    = host_we;
            owner_d     = host_lock ? OWN_HLOCK : OWN_HOST;
            tag_d       = host_we ? TAG_NONE : TAG_HOST;
            if (!host_lock) begin
                lock_cnt_d = {LW{1'b0}};
            end else if (owner_q != OWN_HLOCK) begin
                lock_cnt_d = LW'(1);
            end else if (lock_cnt_q == LOCK_C) begin
                lock_cnt_d = lock_cnt_q;
            end else begin
                lock_cnt_d = lock_cnt_q + LW'(1);
            end
        end else begin
            owner_d = OWN_IDLE;
        end

        // A read tagged before reset asserted is discarded.
        core_rvalid  = (tag_q == TAG_CORE) && !reset;
        host_rvalid  = (tag_q == TAG_HOST) && !reset;
        core_rdata_d = core_rvalid ? mem_rdata : core_rdata_q;
        host_rdata_d = host_rvalid ? mem_rdata : host_rdata_q;
    end

    // State, hold and routing registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_IDLE;
            tag_q        <= TAG_NONE;
            lock_cnt_q   <= {LW{1'b0}};
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            core_rdata_q <= {DATA_W{1'b0}};
            host_rdata_q <= {DATA_W{1'b0}};
        end else begin
            owner_q      <= owner_d;
            tag_q        <= tag_d;
            lock_cnt_q   <= lock_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_d;
    assign mem_wdata  = mem_wdata_d;
    assign mem_we     = mem_we_d;
    assign core_rdata = core_rdata_d;
    assign host_rdata = host_rdata_d;
    assign stall_core = core_req & ~core_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural RAM and read scoreboards.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_gnt, core_rvalid, stall_core;
    logic [15:0] core_addr;
    logic [23:0] core_wdata, core_rdata;
    logic        host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [15:0] host_addr;
    logic [23:0] host_wdata, host_rdata;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata, mem_rdata;
    logic        mem_we;

    logic [23:0] ram [0:1023];
    logic [23:0] core_q[$];
    logic [23:0] host_q[$];
    int checks = 0;
    int errors = 0;
    logic exp_h;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .stall_core(stall_core),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM: data valid the cycle after the command; preloaded during reset.
    always @(posedge clk) begin
        if (reset) begin
            ram[10'd16] <= 24'h00ABCD;
            ram[10'd1]  <= 24'h111111;
            ram[10'd2]  <= 24'h222222;
        end else if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drop_all();
        core_req = 1'b0; core_we = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
    endtask

    // Scoreboard: every rvalid must match the oldest expected read for that port.
    always @(negedge clk) begin
        if (core_rvalid === 1'b1) begin
            if (core_q.size() == 0) chk("core_rvalid_spurious", 32'd1, 32'd0);
            else chk("core_rdata_sb", {8'h00, core_rdata}, {8'h00, core_q.pop_front()});
        end
        if (host_rvalid === 1'b1) begin
            if (host_q.size() == 0) chk("host_rvalid_spurious", 32'd1, 32'd0);
            else chk("host_rdata_sb", {8'h00, host_rdata}, {8'h00, host_q.pop_front()});
        end
    end

    initial begin
        reset = 1'b1;
        drop_all();
        core_addr = 16'h0000; core_wdata = 24'h000000;
        host_addr = 16'h0000; host_wdata = 24'h000000;
        cyc(); cyc();
        settle();
        chk("rst_core_gnt", core_gnt, 1'b0);
        chk("rst_host_gnt", host_gnt, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 24'h000000);
        chk("rst_core_rdata", core_rdata, 24'h000000);
        chk("rst_host_rdata", host_rdata, 24'h000000);
        chk("rst_rvalid", {core_rvalid, host_rvalid}, 2'b00);
        cyc();
        reset = 1'b0;
        cyc();

        // Core alone reads 0x0010.
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010;
        settle();
        chk("a_core_gnt", core_gnt, 1'b1);
        chk("a_stall", stall_core, 1'b0);
        chk("a_mem_addr", mem_addr, 16'h0010);
        chk("a_mem_we", mem_we, 1'b0);
        core_q.push_back(24'h00ABCD);
        cyc();
        core_req = 1'b0;
        settle();
        chk("a_core_rvalid", core_rvalid, 1'b1);
        chk("a_core_rdata", core_rdata, 24'h00ABCD);
        chk("a_host_rvalid", host_rvalid, 1'b0);
        cyc();
        settle();
        chk("a_rvalid_one_cycle", core_rvalid, 1'b0);
        chk("a_rdata_hold", core_rdata, 24'h00ABCD);
        chk("a_mem_addr_hold", mem_addr, 16'h0010);
        cyc();

        // Continuous contention from IDLE.
        core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0300; core_wdata = 24'h0C0C0C;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0301; host_wdata = 24'h0D0D0D;
        for (int i = 0; i < 10; i++) begin
            settle();
`ifdef DMEM_ARB_RR_EN
            exp_h = (i % 2 == 1);
`else
            exp_h = (i == 8);
`endif
            chk($sformatf("b_host_gnt_%0d", i), host_gnt, exp_h);
            chk($sformatf("b_core_gnt_%0d", i), core_gnt, !exp_h);
            chk($sformatf("b_stall_%0d", i), stall_core, exp_h);
            chk($sformatf("b_mem_addr_%0d", i), mem_addr, exp_h ? 16'h0301 : 16'h0300);
            cyc();
        end
        drop_all();
        cyc(); cyc();

        // Locked host burst of 6 cycles; core joins on the second cycle.
        host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
        host_addr = 16'h0200; host_wdata = 24'h123456;
        settle();
        chk("c_host_gnt_0", host_gnt, 1'b1);
        chk("c_mem_we_0", mem_we, 1'b1);
        chk("c_mem_wdata_0", mem_wdata, 24'h123456);
        cyc();
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0200;
        for (int i = 1; i < 4; i++) begin
            settle();
            chk($sformatf("c_host_gnt_%0d", i), host_gnt, 1'b1);
            chk($sformatf("c_core_gnt_%0d", i), core_gnt, 1'b0);
            chk($sformatf("c_stall_%0d", i), stall_core, 1'b1);
            cyc();
        end
        settle();
        chk("c_core_gnt_4", core_gnt, 1'b1);
        chk("c_host_gnt_4", host_gnt, 1'b0);
        chk("c_mem_we_4", mem_we, 1'b0);
        core_q.push_back(24'h123456);
        cyc();
        core_req = 1'b0;
        settle();
        chk("c_host_gnt_5", host_gnt, 1'b1);
        cyc();
        drop_all();
        cyc();

        // Alternating single reads: core @0x1 then host @0x2.
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0001;
        settle();
        chk("d_core_gnt", core_gnt, 1'b1);
        core_q.push_back(24'h111111);
        cyc();
        core_req = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0002;
        settle();
        chk("d_host_gnt", host_gnt, 1'b1);
        chk("d_core_rvalid", core_rvalid, 1'b1);
        chk("d_host_rvalid_early", host_rvalid, 1'b0);
        chk("d_core_rdata", core_rdata, 24'h111111);
        host_q.push_back(24'h222222);
        cyc();
        host_req = 1'b0;
        settle();
        chk("d_host_rvalid", host_rvalid, 1'b1);
        chk("d_core_rvalid_off", core_rvalid, 1'b0);
        chk("d_host_rdata", host_rdata, 24'h222222);
        chk("d_core_rdata_hold", core_rdata, 24'h111111);
        cyc();

        // Reset right after a core read grant drops the read.
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010;
        settle();
        chk("e_core_gnt", core_gnt, 1'b1);
        cyc();
        reset = 1'b1;
        settle();
        chk("e_gnt_forced_off", core_gnt, 1'b0);
        chk("e_no_rvalid", core_rvalid, 1'b0);
        chk("e_mem_we", mem_we, 1'b0);
        cyc();
        reset = 1'b0;
        core_req = 1'b0;
        settle();
        chk("e_core_rvalid", core_rvalid, 1'b0);
        chk("e_host_rvalid", host_rvalid, 1'b0);
        chk("e_core_rdata", core_rdata, 24'h000000);
        chk("e_host_rdata", host_rdata, 24'h000000);
        chk("e_mem_addr", mem_addr, 16'h0000);
        chk("e_mem_wdata", mem_wdata, 24'h000000);
        chk("e_gnts", {core_gnt, host_gnt}, 2'b00);
        cyc();

        // Core write then read of the same address, back to back.
        core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0040; core_wdata = 24'h5A5A5A;
        settle();
        chk("f_wr_gnt", core_gnt, 1'b1);
        chk("f_wr_mem_we", mem_we, 1'b1);
        cyc();
        core_we = 1'b0;
        settle();
        chk("f_rd_gnt", core_gnt, 1'b1);
        chk("f_no_wr_rvalid", core_rvalid, 1'b0);
        core_q.push_back(24'h5A5A5A);
        cyc();
        core_req = 1'b0;
        settle();
        chk("f_rvalid", core_rvalid, 1'b1);
        chk("f_rdata", core_rdata, 24'h5A5A5A);
        cyc(); cyc();

        chk("sb_core_empty", core_q.size(), 32'd0);
        chk("sb_host_empty", host_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
